// File: rtl/sha256_compress_pkg.sv
// sha256_compress_pkg: SHA-256 constants, bitwise round functions and FSM state type.
package sha256_compress_pkg;
    typedef enum logic [1:0] {IDLE, ROUND, ADD} state_t;
    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction
    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction
    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return ror32(x, 2) ^ ror32(x, 13) ^ ror32(x, 22);
    endfunction
    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return ror32(x, 6) ^ ror32(x, 11) ^ ror32(x, 25);
    endfunction
    // Message-schedule sigmas, used by the schedule stage that feeds this core.
    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return ror32(x, 7) ^ ror32(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return ror32(x, 17) ^ ror32(x, 19) ^ (x >> 10);
    endfunction
endpackage

// File: rtl/sha256_compress_if.sv
// sha256_compress_if: block start, schedule word stream and digest between the
// schedule stage (master) and the compression core (slave).
interface sha256_compress_if;
    logic         start;
    logic         init_hash;
    logic         w_valid;
    logic [31:0]  w;
    logic         busy;
    logic         done;
    logic [255:0] digest;
    modport master (output start, init_hash, w_valid, w, input busy, done, digest);
    modport slave (input start, init_hash, w_valid, w, output busy, done, digest);
endinterface

// File: rtl/sha256_compress_k_rom.sv
// sha256_compress_k_rom: combinational round-constant lookup K[t].
module sha256_compress_k_rom
    import sha256_compress_pkg::*;
(
    input  logic [5:0]  i_t,
    output logic [31:0] o_k
);
    assign o_k = K[i_t];
endmodule

// File: rtl/sha256_compress.sv
// sha256_compress: one SHA-256 round per valid schedule word, then a single ADD
// cycle folds the working variables a..h into the chaining state H0..H7.
module sha256_compress
    import sha256_compress_pkg::*;
#(
    parameter int ROUNDS = 64
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    sha256_compress_if.slave bus
);
    localparam logic [5:0] LAST = 6'(ROUNDS - 1);
    state_t      r_state;
    logic [5:0]  r_t;
    logic [31:0] r_h [8];
    logic [31:0] r_v [8];
    logic        r_busy;
    logic        r_done;
    logic [31:0] w_k;
    logic [31:0] w_t1;
    logic [31:0] w_t2;
    sha256_compress_k_rom u_k_rom (.i_t(r_t), .o_k(w_k));
    // r_v[0..7] hold a..h
    assign w_t1 = r_v[7] + big_sigma1(r_v[4]) + ch(r_v[4], r_v[5], r_v[6]) + w_k + bus.w;
    assign w_t2 = big_sigma0(r_v[0]) + maj(r_v[0], r_v[1], r_v[2]);
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.digest = {r_h[0], r_h[1], r_h[2], r_h[3], r_h[4], r_h[5], r_h[6], r_h[7]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_t     <= '0;
            r_h     <= IV;
            r_v     <= '{default: '0};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (i_clear) begin
            r_state <= IDLE;
            r_t     <= '0;
            r_h     <= IV;
            r_v     <= '{default: '0};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        for (int i = 0; i < 8; i++) r_v[i] <= bus.init_hash ? IV[i] : r_h[i];
                        if (bus.init_hash) r_h <= IV;
                        r_t     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ROUND;
                    end
                end
                ROUND: begin
                    if (bus.w_valid) begin
                        for (int i = 1; i < 8; i++) r_v[i] <= r_v[i-1];
                        r_v[4]  <= r_v[3] + w_t1;
                        r_v[0]  <= w_t1 + w_t2;
                        r_t     <= (r_t == LAST) ? 6'd0 : r_t + 6'd1;
                        r_state <= (r_t == LAST) ? ADD : ROUND;
                    end
                end
                ADD: begin
                    for (int i = 0; i < 8; i++) r_h[i] <= r_h[i] + r_v[i];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_compress.sv
// tb_sha256_compress: directed SHA-256 blocks against a whole-block software model
// of FIPS 180-4 compression, with literal digests pinning the model.
module tb_sha256_compress;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;
    sha256_compress_if bus ();
    sha256_compress #(.ROUNDS(64)) dut (.clk(clk), .rst_n(rst_n), .i_clear(clear), .bus(bus));
    localparam logic [255:0] IV256   = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [255:0] exp_digest = IV256;
    logic [255:0] model_h = IV256;
    logic [255:0] exp_q [$];
    logic [31:0] blk_empty [16];
    logic [31:0] blk_abc [16];
    logic [31:0] blk_two_a [16];
    logic [31:0] blk_two_b [16];
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic void expand(input logic [31:0] blk [16], output logic [31:0] w [64]);
        for (int t = 0; t < 64; t++)
            w[t] = (t < 16) ? blk[t] :
                (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7] +
                (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [31:0] w [64]);
        logic [31:0] hh [8];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 8; i++) hh[i] = hin[255-32*i -: 32];
        v = hh;
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) +
                 ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) +
                 ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hh[i] + v[i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Digest must equal the last expected H except in a done cycle, where it must be the next queued result.
    always @(negedge clk) begin
        if (bus.done) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL done_unexpected: got done=1 expected no pending block");
            end else begin
                chk("digest_at_done", bus.digest, exp_q[0]);
                exp_digest = exp_q.pop_front();
            end
        end else begin
            chk("digest_stable", bus.digest, exp_digest);
        end
    end

    // abort_kind: 0 = rst_n pulse, 1 = clear pulse, taken just before round abort_at.
    task automatic run_block(input string name, input logic init, input logic [31:0] blk [16],
                             input int max_gap, input bit pulse_start, input int abort_at, input int abort_kind);
        logic [31:0] w [64];
        int gap;
        int c0;
        logic got;
        expand(blk, w);
        model_h = compress(init ? IV256 : model_h, w);
        exp_q.push_back(model_h);
        bus.start = 1'b1;
        bus.init_hash = init;
        c0 = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (init) exp_digest = IV256;
        for (int t = 0; t < 64; t++) begin
            if (t == abort_at) begin
                exp_q.delete();
                model_h = IV256;
                if (abort_kind == 0) begin
                    rst_n = 1'b0;
                    exp_digest = IV256;
                    #1;
                    chk({name, "_rstn_busy"}, bus.busy, 0);
                    chk({name, "_rstn_done"}, bus.done, 0);
                    chk({name, "_rstn_digest"}, bus.digest, IV256);
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                end else begin
                    clear = 1'b1;
                    bus.start = 1'b1;
                    bus.init_hash = 1'b0;
                    bus.w_valid = 1'b1;
                    bus.w = w[t];
                    @(posedge clk); #1;
                    exp_digest = IV256;
                    clear = 1'b0;
                    bus.start = 1'b0;
                    bus.w_valid = 1'b0;
                    chk({name, "_clr_busy"}, bus.busy, 0);
                    chk({name, "_clr_done"}, bus.done, 0);
                    chk({name, "_clr_digest"}, bus.digest, IV256);
                end
                return;
            end
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (gap) begin
                bus.w_valid = 1'b0;
                bus.start = pulse_start;
                bus.init_hash = 1'b1;
                bus.w = $urandom;
                @(posedge clk); #1;
                chk({name, "_busy_gap"}, bus.busy, 1);
            end
            bus.w_valid = 1'b1;
            bus.w = w[t];
            bus.start = pulse_start;
            @(posedge clk); #1;
            chk({name, "_busy_round"}, bus.busy, 1);
        end
        bus.w_valid = 1'b0;
        bus.start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(posedge clk); #1;
            got = bus.done;
        end
        chk({name, "_done_seen"}, got, 1);
        if (got) begin
            chk({name, "_busy_at_done"}, bus.busy, 0);
            // Cycles from driving start to done visible: 1 start + 64 rounds + 1 ADD.
            if (max_gap == 0) chk({name, "_latency"}, cyc - c0, 66);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected end before 200000");
        $fatal(1);
    end

    initial begin
        blk_empty = '{32'h80000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        blk_abc   = '{32'h61626380, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00000018};
        blk_two_a = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        blk_two_b = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h000001c0};
        bus.start = 1'b0;
        bus.init_hash = 1'b0;
        bus.w_valid = 1'b0;
        bus.w = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_digest", bus.digest, IV256);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_block("empty", 1'b1, blk_empty, 0, 1'b0, -1, 0);
        chk("empty_model_lit", model_h, D_EMPTY);
        chk("empty_dut_lit", bus.digest, D_EMPTY);
        for (int i = 0; i < 5; i++) begin
            bus.w_valid = 1'b1;
            bus.w = $urandom;
            @(posedge clk); #1;
            chk("idle_wvalid_busy", bus.busy, 0);
        end
        bus.w_valid = 1'b0;
        run_block("abc", 1'b1, blk_abc, 0, 1'b0, -1, 0);
        chk("abc_model_lit", model_h, D_ABC);
        chk("abc_dut_lit", bus.digest, D_ABC);
        run_block("two_a", 1'b1, blk_two_a, 0, 1'b0, -1, 0);
        run_block("two_b", 1'b0, blk_two_b, 0, 1'b0, -1, 0);
        chk("two_model_lit", model_h, D_TWO);
        chk("two_dut_lit", bus.digest, D_TWO);
        run_block("abc_gaps", 1'b1, blk_abc, 5, 1'b1, -1, 0);
        chk("abc_gaps_dut_lit", bus.digest, D_ABC);
        run_block("two_a2", 1'b1, blk_two_a, 0, 1'b0, -1, 0);
        run_block("abort_rstn", 1'b0, blk_abc, 0, 1'b0, 30, 0);
        run_block("after_rstn", 1'b0, blk_abc, 0, 1'b0, -1, 0);
        chk("after_rstn_dut_lit", bus.digest, D_ABC);
        run_block("two_a3", 1'b1, blk_two_a, 0, 1'b0, -1, 0);
        run_block("abort_clr", 1'b0, blk_abc, 0, 1'b0, 30, 1);
        run_block("after_clr", 1'b0, blk_abc, 0, 1'b0, -1, 0);
        chk("after_clr_dut_lit", bus.digest, D_ABC);
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
